int_pow_log: RTL and testbench
==============================

INT_POW_LOG -- requirements
Module: int_pow_log

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits (SHALL be >= 4).
REQ-002 Parameter EXPW, default 8, width of the exponent input.
REQ-003 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset; rst=0 SHALL reset the block immediately regardless of clk.
REQ-005 start  in  1  request; SHALL be sampled only in IDLE.
REQ-006 mode  in  1  operation select: 0 = LOG, 1 = POW.
REQ-007 base  in  WIDTH  base operand (unsigned).
REQ-008 target  in  WIDTH  LOG operand (unsigned); ignored in POW.
REQ-009 exp_in  in  EXPW  POW exponent (unsigned); ignored in LOG.
REQ-010 busy  out  1  high in RUN.
REQ-011 done  out  1  single-cycle completion pulse.
REQ-012 result  out  WIDTH  answer; held from done until the next accepted start.
REQ-013 ovf  out  1  POW result saturated; valid with result.
REQ-014 err  out  1  illegal LOG operands; valid with result.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE, with one iteration per RUN cycle.
REQ-016 IDLE with start=1: latch mode, base, target and exp_in; set acc=1 and cnt=0 (LOG) or cnt=exp_in (POW); clear ovf and err; next state RUN.
REQ-017 Operands SHALL be latched only on an accepted start; input changes during RUN SHALL be ignored.
REQ-018 start asserted in RUN or DONE SHALL be ignored and not queued.
REQ-019 LOG: result SHALL be floor(log_base(target)), the largest e with base^e <= target.
REQ-020 LOG iteration: form p = acc*base at 2*WIDTH bits; if p > target go to DONE with result=cnt, else acc=p[WIDTH-1:0] and cnt=cnt+1.
REQ-021 LOG with base < 2 or target = 0: go IDLE->DONE directly with err=1 and result=0; no RUN cycles.
REQ-022 POW: result SHALL be base^exp_in, saturated to all-ones on overflow.
REQ-023 POW iteration: if cnt=0 go to DONE with result=acc; else p = acc*base at 2*WIDTH bits.
REQ-024 POW iteration (cont.): if p[2W-1:W] != 0, go to DONE with result all-ones and ovf=1; else acc=p[WIDTH-1:0] and cnt=cnt-1.
REQ-025 POW SHALL give 0^0=1, x^0=1 and 0^n=0 for n > 0; none of these sets ovf.
REQ-026 Latency: done SHALL assert one clock after the final RUN evaluation.
REQ-027 LOG latency SHALL be result+2 edges after the start-sampling edge.
REQ-028 POW latency SHALL be exp_in+2 edges, or fewer when overflow terminates early.
REQ-029 Iterations SHALL be bounded: LOG <= WIDTH+1 RUN cycles (base >= 2); POW <= 2^EXPW RUN cycles.
REQ-030 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-031 A start in the cycle after DONE (in IDLE) SHALL be accepted normally.
REQ-032 result, ovf and err SHALL change only on the DONE-entry edge or on reset.
REQ-033 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.

Reset
REQ-034 While rst=0: state=IDLE; busy, done, ovf and err = 0; result=0; acc=1; cnt=0.
REQ-035 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-036 After reset release, the block SHALL accept start on the first rising edge.

Verification
REQ-037 LOG base=3, target=27 -> result=3, err=0; done 5 edges after start.
REQ-038 LOG base=2, target=0xFFFF (WIDTH=16) -> result=15; base=10, target=9 -> result=0; base=1 -> err=1, result=0, done 1 edge after start.
REQ-039 POW base=3, exp_in=10 -> result=59049, ovf=0; base=2, exp_in=16 -> result=0xFFFF, ovf=1, done before exp_in+2 edges; base=0, exp_in=0 -> result=1.
REQ-040 start re-pulsed and operands changed during RUN -> no effect on result.
REQ-041 Back-to-back start immediately after done -> second result correct.
REQ-042 rst=0 mid-RUN, then released -> no done; next start completes correctly.
REQ-043 Randomised base, target and exp_in, WIDTH=8 and 16, checked against a golden model.

Source files
------------

// File: rtl/int_pow_log.sv
// int_pow_log: iterative unsigned integer power (saturating) and floor-log,
// one acc*base multiply per RUN cycle.
module int_pow_log #(
  parameter int WIDTH = 16,
  parameter int EXPW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] target,
  input  logic [EXPW-1:0]  exp_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             err
);
  localparam int LW = $clog2(WIDTH + 2);
  localparam int CW = (EXPW > LW) ? EXPW : LW;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   base_q, base_d, target_q, target_d, acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovf_q, ovf_d, err_q, err_d, busy_q, done_q;
  logic [2*WIDTH-1:0] p;
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    base_d   = base_q;
    target_d = target_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    p        = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, base_q};
    case (state_q)
      IDLE: if (start) begin
        mode_d   = mode;
        base_d   = base;
        target_d = target;
        acc_d    = WIDTH'(1);
        cnt_d    = mode ? CW'(exp_in) : '0;
        // illegal LOG operands finish without any RUN cycle
        if (!mode && (base < WIDTH'(2) || target == '0)) begin
          state_d  = DONE;
          result_d = '0;
          ovf_d    = 1'b0;
          err_d    = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: if (!mode_q) begin
        if (p > {{WIDTH{1'b0}}, target_q}) begin
          state_d  = DONE;
          result_d = WIDTH'(cnt_q);
          ovf_d    = 1'b0;
          err_d    = 1'b0;
        end else begin
          acc_d = p[WIDTH-1:0];
          cnt_d = cnt_q + CW'(1);
        end
      end else if (cnt_q == '0) begin
        state_d  = DONE;
        result_d = acc_q;
        ovf_d    = 1'b0;
        err_d    = 1'b0;
      end else if (|p[2*WIDTH-1:WIDTH]) begin
        state_d  = DONE;
        result_d = '1;
        ovf_d    = 1'b1;
        err_d    = 1'b0;
      end else begin
        acc_d = p[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      base_q   <= '0;
      target_q <= '0;
      acc_q    <= WIDTH'(1);
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      base_q   <= base_d;
      target_q <= target_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign err    = err_q;
endmodule

// File: tb/tb_int_pow_log.sv
// tb_int_pow_log: scoreboard bench driving a 16-bit and an 8-bit instance in parallel.
module tb_int_pow_log;
  logic clk = 0, rst = 1, start = 0, mode = 0;
  logic [15:0] base = 0, target = 0;
  logic [7:0] exp_in = 0;
  logic busy16, done16, ovf16, err16, busy8, done8, ovf8, err8;
  logic [15:0] res16;
  logic [7:0] res8;
  logic pd16 = 0, pd8 = 0;
  int checks = 0, errors = 0, cyc = 0, nid = 0;
  typedef struct {logic [15:0] r; logic o; logic e; int lat; int t0; int id;} exp_t;
  exp_t q16[$], q8[$];
  int_pow_log #(.WIDTH(16), .EXPW(8)) dut16 (.clk(clk), .rst(rst), .start(start), .mode(mode),
    .base(base), .target(target), .exp_in(exp_in), .busy(busy16), .done(done16),
    .result(res16), .ovf(ovf16), .err(err16));
  int_pow_log #(.WIDTH(8), .EXPW(8)) dut8 (.clk(clk), .rst(rst), .start(start), .mode(mode),
    .base(base[7:0]), .target(target[7:0]), .exp_in(exp_in), .busy(busy8), .done(done8),
    .result(res8), .ovf(ovf8), .err(err8));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic exp_t gold(input int w, input bit m, input longint b, input longint t, input longint e);
    exp_t x;
    longint mask, pw, n;
    mask = (longint'(1) << w) - 1;
    x.o = 0; x.e = 0; x.t0 = 0; x.id = 0;
    if (!m) begin
      if (b < 2 || t == 0) begin
        x.r = 0; x.e = 1; x.lat = 1;
      end else begin
        n = 0; pw = b;
        while (pw <= t) begin n++; pw *= b; end
        x.r = 16'(n); x.lat = int'(n) + 2;
      end
    end else begin
      pw = 1; x.lat = int'(e) + 2;
      for (longint i = 0; i < e; i++) begin
        pw *= b;
        if (pw > mask) begin pw = mask; x.o = 1; x.lat = int'(i) + 2; break; end
      end
      x.r = pw[15:0];
    end
    return x;
  endfunction
  task automatic score(input int k, input logic d, input logic pd, input logic [15:0] r, input logic o, input logic e);
    exp_t x;
    if (d && pd) begin
      checks++; errors++;
      $display("FAIL done_pulse w%0d: done high two cycles, required one", k);
    end
    if (!d) return;
    checks++;
    if ((k == 16 ? q16.size() : q8.size()) == 0) begin
      errors++;
      $display("FAIL stray_done w%0d: done with no outstanding request, result=%0h", k, r);
      return;
    end
    if (k == 16) x = q16.pop_front(); else x = q8.pop_front();
    if (r !== x.r || o !== x.o || e !== x.e || cyc - x.t0 != x.lat) begin
      errors++;
      $display("FAIL op%0d w%0d: got result=%0h ovf=%0b err=%0b lat=%0d, expected result=%0h ovf=%0b err=%0b lat=%0d",
               x.id, k, r, o, e, cyc - x.t0, x.r, x.o, x.e, x.lat);
    end
  endtask
  always @(negedge clk) begin
    score(16, done16, pd16, res16, ovf16, err16);
    score(8, done8, pd8, {8'b0, res8}, ovf8, err8);
    pd16 <= done16;
    pd8 <= done8;
  end
  task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((q16.size() != 0 || q8.size() != 0 || done16 || done8 || busy16 || busy8) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      checks++; errors++;
      $display("FAIL timeout: outstanding w16=%0d w8=%0d", q16.size(), q8.size());
      q16.delete(); q8.delete();
    end
  endtask
  task automatic issue(input bit m, input logic [15:0] b, input logic [15:0] t, input logic [7:0] e,
                       input bit track, input bit hand, input logic [15:0] hr, input bit ho, input bit he, input int hl);
    exp_t x16, x8;
    wait_idle();
    mode = m; base = b; target = t; exp_in = e; start = 1;
    if (hand) begin
      x16.r = hr; x16.o = ho; x16.e = he; x16.lat = hl;
    end else begin
      x16 = gold(16, m, b, t, e);
    end
    x8 = gold(8, m, longint'(b[7:0]), longint'(t[7:0]), e);
    x16.t0 = cyc; x16.id = nid; x8.t0 = cyc; x8.id = nid;
    nid++;
    if (track) begin q16.push_back(x16); q8.push_back(x8); end
    @(negedge clk);
    start = 0;
  endtask
  initial begin
    #1 rst = 0;
    #1;
    chk("rst_busy", {15'b0, busy16}, 16'h0);
    chk("rst_done", {15'b0, done16}, 16'h0);
    chk("rst_result", res16, 16'h0);
    chk("rst_ovf_err", {14'b0, ovf16, err16}, 16'h0);
    @(negedge clk) rst = 1;
    issue(0, 16'd3, 16'd27, 8'd0, 1, 1, 16'd3, 0, 0, 5);
    issue(0, 16'd2, 16'hFFFF, 8'd0, 1, 1, 16'd15, 0, 0, 17);
    issue(0, 16'd10, 16'd9, 8'd0, 1, 1, 16'd0, 0, 0, 2);
    issue(0, 16'd1, 16'd100, 8'd0, 1, 1, 16'd0, 0, 1, 1);
    issue(0, 16'd5, 16'd0, 8'd0, 1, 1, 16'd0, 0, 1, 1);
    issue(0, 16'd2, 16'd1, 8'd0, 1, 1, 16'd0, 0, 0, 2);
    issue(0, 16'd16, 16'hFFFF, 8'd0, 1, 1, 16'd3, 0, 0, 5);
    issue(1, 16'd2, 16'd0, 8'd16, 1, 1, 16'hFFFF, 1, 0, 17);
    issue(1, 16'd0, 16'd0, 8'd0, 1, 1, 16'd1, 0, 0, 2);
    issue(1, 16'd0, 16'd0, 8'd5, 1, 1, 16'd0, 0, 0, 7);
    issue(1, 16'd7, 16'd0, 8'd0, 1, 1, 16'd1, 0, 0, 2);
    issue(1, 16'd2, 16'd0, 8'd15, 1, 1, 16'h8000, 0, 0, 17);
    issue(1, 16'd3, 16'd0, 8'd10, 1, 1, 16'd59049, 0, 0, 12);
    chk("busy_in_run", {15'b0, busy16}, 16'h1);
    repeat (2) @(negedge clk);
    mode = 0; base = 16'd5; target = 16'd7; exp_in = 8'd1; start = 1;
    @(negedge clk) start = 0;
    for (int i = 0; i < 10; i++)
      issue(1'($urandom_range(0, 1)), (i % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 12)),
            16'($urandom), 8'($urandom_range(0, 20)), 1, 0, 16'd0, 0, 0, 0);
    issue(0, 16'd2, 16'hFFFF, 8'd0, 0, 0, 16'd0, 0, 0, 0);
    repeat (4) @(negedge clk);
    rst = 0;
    #1;
    chk("abort_busy", {14'b0, busy16, busy8}, 16'h0);
    chk("abort_result", res16, 16'h0);
    @(negedge clk) rst = 1;
    repeat (25) @(negedge clk);
    issue(0, 16'd3, 16'd27, 8'd0, 1, 1, 16'd3, 0, 0, 5);
    issue(1, 16'd5, 16'd0, 8'd3, 1, 1, 16'd125, 0, 0, 5);
    wait_idle();
    repeat (30) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
